cache_mem_arbiter: RTL and testbench

Shares one external memory bus between the instruction-cache refill port and the data-cache port. It arbitrates commands round-robin and holds the grant until the command fires. For reads it keeps ownership until every response beat has returned, and it routes each beat back to the requester that issued the read. It sits between the two cache blocks and the system memory bus, and only one transaction is outstanding at a time.

---
 rtl/cache_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares one external memory bus between the instruction-cache refill port
// (iBus, reads only) and the data-cache port (dBus, reads and writes).
// Commands are arbitrated round-robin with a zero-cycle combinational path to
// the memory bus. A grant is held until the command fires. Reads then keep
// ownership until every response beat has been routed back to the owner.
// Only one transaction is outstanding at a time.
module cache_mem_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        io_iBus_cmd_valid,
  output logic        io_iBus_cmd_ready,
  input  logic [31:0] io_iBus_cmd_payload_address,
  input  logic [2:0]  io_iBus_cmd_payload_size,
  output logic        io_iBus_rsp_valid,
  output logic [31:0] io_iBus_rsp_payload_data,
  output logic        io_iBus_rsp_payload_error,

  input  logic        io_dBus_cmd_valid,
  output logic        io_dBus_cmd_ready,
  input  logic        io_dBus_cmd_payload_wr,
  input  logic [31:0] io_dBus_cmd_payload_address,
  input  logic [31:0] io_dBus_cmd_payload_data,
  input  logic [3:0]  io_dBus_cmd_payload_mask,
  input  logic [2:0]  io_dBus_cmd_payload_size,
  output logic        io_dBus_rsp_valid,
  output logic [31:0] io_dBus_rsp_payload_data,
  output logic        io_dBus_rsp_payload_error,

  output logic        io_mem_cmd_valid,
  input  logic        io_mem_cmd_ready,
  output logic        io_mem_cmd_payload_wr,
  output logic [31:0] io_mem_cmd_payload_address,
  output logic [31:0] io_mem_cmd_payload_data,
  output logic [3:0]  io_mem_cmd_payload_mask,
  output logic [2:0]  io_mem_cmd_payload_size,
  input  logic        io_mem_rsp_valid,
  input  logic [31:0] io_mem_rsp_payload_data,
  input  logic        io_mem_rsp_payload_error,

  output logic        io_busy,
  output logic        io_protocolError
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    RSP    = 2'd2
  } state_t;

  typedef enum logic {
    SRC_IBUS = 1'b0,
    SRC_DBUS = 1'b1
  } source_t;

  state_t     state;
  source_t    lastGrant;
  source_t    owner;
  logic [5:0] beatCnt;
  logic       busyReg;
  logic       protocolErrorReg;

  source_t    idleWinner;
  source_t    cmdSel;
  logic       cmdPhase;
  logic       selValid;
  logic       cmdFire;
  logic       rspBeat;

  // Number of response beats a read of the given size returns:
  // up to a word is one beat, larger reads are whole words.
  function automatic logic [5:0] beatsForSize(input logic [2:0] size);
    if (size <= 3'd2) begin
      return 6'd1;
    end
    return 6'd1 << (size - 3'd2);
  endfunction

  // Round-robin winner while idle and the source the command mux follows.
  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    idleWinner = SRC_IBUS;
    if (io_dBus_cmd_valid && (!io_iBus_cmd_valid || lastGrant == SRC_IBUS)) begin
      idleWinner = SRC_DBUS;
    end
    cmdSel   = (state == LOCKED) ? owner : idleWinner;
    // NOTE: the handshake outputs are gated with reset so nothing can fire or
    // be delivered in the reset cycle, whatever state the registers hold.
    cmdPhase = !reset && (state != RSP);
    selValid = (cmdSel == SRC_DBUS) ? io_dBus_cmd_valid : io_iBus_cmd_valid;
  end

  // Command mux: the selected requester's payload drives the memory bus.
  always_comb begin
    io_mem_cmd_valid           = cmdPhase && selValid;
    io_iBus_cmd_ready          = cmdPhase && (cmdSel == SRC_IBUS) && io_mem_cmd_ready;
    io_dBus_cmd_ready          = cmdPhase && (cmdSel == SRC_DBUS) && io_mem_cmd_ready;
    io_mem_cmd_payload_wr      = 1'b0;
    io_mem_cmd_payload_address = io_iBus_cmd_payload_address;
    io_mem_cmd_payload_data    = 32'h0;
    io_mem_cmd_payload_mask    = 4'hF;
    io_mem_cmd_payload_size    = io_iBus_cmd_payload_size;
    if (cmdSel == SRC_DBUS) begin
      io_mem_cmd_payload_wr      = io_dBus_cmd_payload_wr;
      io_mem_cmd_payload_address = io_dBus_cmd_payload_address;
      io_mem_cmd_payload_data    = io_dBus_cmd_payload_data;
      io_mem_cmd_payload_mask    = io_dBus_cmd_payload_mask;
      io_mem_cmd_payload_size    = io_dBus_cmd_payload_size;
    end
    cmdFire = io_mem_cmd_valid && io_mem_cmd_ready;
  end

  // Response routing: data and error go to both ports, valid only to the owner.
  always_comb begin
    rspBeat                   = !reset && (state == RSP) && io_mem_rsp_valid;
    io_iBus_rsp_valid         = rspBeat && (owner == SRC_IBUS);
    io_dBus_rsp_valid         = rspBeat && (owner == SRC_DBUS);
    io_iBus_rsp_payload_data  = io_mem_rsp_payload_data;
    io_iBus_rsp_payload_error = io_mem_rsp_payload_error;
    io_dBus_rsp_payload_data  = io_mem_rsp_payload_data;
    io_dBus_rsp_payload_error = io_mem_rsp_payload_error;
  end

  assign io_busy          = busyReg;
  assign io_protocolError = protocolErrorReg;

  // Arbitration state machine with registered busy and sticky protocol error.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every branch
    // below sees the values from before this clock edge.
    if (reset) begin
      state            <= IDLE;
      lastGrant        <= SRC_IBUS;
      owner            <= SRC_IBUS;
      beatCnt          <= 6'd0;
      busyReg          <= 1'b0;
      protocolErrorReg <= 1'b0;
    end else begin
      // A beat with no read outstanding is dropped and flagged until reset.
      if (io_mem_rsp_valid && state != RSP) begin
        protocolErrorReg <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (io_mem_cmd_valid) begin
            owner <= cmdSel;
            if (cmdFire) begin
              lastGrant <= cmdSel;
              if (!io_mem_cmd_payload_wr) begin
                state   <= RSP;
                beatCnt <= beatsForSize(io_mem_cmd_payload_size);
                busyReg <= 1'b1;
              end
            end else begin
              state   <= LOCKED;
              busyReg <= 1'b1;
            end
          end
        end

        LOCKED: begin
          if (cmdFire) begin
            lastGrant <= owner;
            if (io_mem_cmd_payload_wr) begin
              state   <= IDLE;
              busyReg <= 1'b0;
            end else begin
              state   <= RSP;
              beatCnt <= beatsForSize(io_mem_cmd_payload_size);
            end
          end
        end

        RSP: begin
          if (rspBeat) begin
            beatCnt <= beatCnt - 6'd1;
            if (beatCnt == 6'd1) begin
              state   <= IDLE;
              busyReg <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: a table of idle arbitration
// vectors followed by directed multi-cycle sequences (refill, tie-break,
// grant hold, error beat, stray response, beat counts, reset mid-burst).
module tb_cache_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        io_iBus_cmd_valid, io_iBus_cmd_ready;
  logic [31:0] io_iBus_cmd_payload_address;
  logic [2:0]  io_iBus_cmd_payload_size;
  logic        io_iBus_rsp_valid, io_iBus_rsp_payload_error;
  logic [31:0] io_iBus_rsp_payload_data;
  logic        io_dBus_cmd_valid, io_dBus_cmd_ready, io_dBus_cmd_payload_wr;
  logic [31:0] io_dBus_cmd_payload_address, io_dBus_cmd_payload_data;
  logic [3:0]  io_dBus_cmd_payload_mask;
  logic [2:0]  io_dBus_cmd_payload_size;
  logic        io_dBus_rsp_valid, io_dBus_rsp_payload_error;
  logic [31:0] io_dBus_rsp_payload_data;
  logic        io_mem_cmd_valid, io_mem_cmd_ready, io_mem_cmd_payload_wr;
  logic [31:0] io_mem_cmd_payload_address, io_mem_cmd_payload_data;
  logic [3:0]  io_mem_cmd_payload_mask;
  logic [2:0]  io_mem_cmd_payload_size;
  logic        io_mem_rsp_valid, io_mem_rsp_payload_error;
  logic [31:0] io_mem_rsp_payload_data;
  logic        io_busy, io_protocolError;

  cache_mem_arbiter dut (
    .clk                         (clk),
    .reset                       (reset),
    .io_iBus_cmd_valid           (io_iBus_cmd_valid),
    .io_iBus_cmd_ready           (io_iBus_cmd_ready),
    .io_iBus_cmd_payload_address (io_iBus_cmd_payload_address),
    .io_iBus_cmd_payload_size    (io_iBus_cmd_payload_size),
    .io_iBus_rsp_valid           (io_iBus_rsp_valid),
    .io_iBus_rsp_payload_data    (io_iBus_rsp_payload_data),
    .io_iBus_rsp_payload_error   (io_iBus_rsp_payload_error),
    .io_dBus_cmd_valid           (io_dBus_cmd_valid),
    .io_dBus_cmd_ready           (io_dBus_cmd_ready),
    .io_dBus_cmd_payload_wr      (io_dBus_cmd_payload_wr),
    .io_dBus_cmd_payload_address (io_dBus_cmd_payload_address),
    .io_dBus_cmd_payload_data    (io_dBus_cmd_payload_data),
    .io_dBus_cmd_payload_mask    (io_dBus_cmd_payload_mask),
    .io_dBus_cmd_payload_size    (io_dBus_cmd_payload_size),
    .io_dBus_rsp_valid           (io_dBus_rsp_valid),
    .io_dBus_rsp_payload_data    (io_dBus_rsp_payload_data),
    .io_dBus_rsp_payload_error   (io_dBus_rsp_payload_error),
    .io_mem_cmd_valid            (io_mem_cmd_valid),
    .io_mem_cmd_ready            (io_mem_cmd_ready),
    .io_mem_cmd_payload_wr       (io_mem_cmd_payload_wr),
    .io_mem_cmd_payload_address  (io_mem_cmd_payload_address),
    .io_mem_cmd_payload_data     (io_mem_cmd_payload_data),
    .io_mem_cmd_payload_mask     (io_mem_cmd_payload_mask),
    .io_mem_cmd_payload_size     (io_mem_cmd_payload_size),
    .io_mem_rsp_valid            (io_mem_rsp_valid),
    .io_mem_rsp_payload_data     (io_mem_rsp_payload_data),
    .io_mem_rsp_payload_error    (io_mem_rsp_payload_error),
    .io_busy                     (io_busy),
    .io_protocolError            (io_protocolError)
  );

  int checks   = 0;
  int failures = 0;

  // Command-side outputs packed for one-shot comparison:
  // {valid, iReady, dReady, wr, address, data, mask, size}
  logic [74:0] cmdOut;
  assign cmdOut = {io_mem_cmd_valid, io_iBus_cmd_ready, io_dBus_cmd_ready,
                   io_mem_cmd_payload_wr, io_mem_cmd_payload_address,
                   io_mem_cmd_payload_data, io_mem_cmd_payload_mask,
                   io_mem_cmd_payload_size};

  typedef struct {
    logic        iValid;
    logic        dValid;
    logic        dWr;
    logic        memReady;
    logic [74:0] expCmd;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [74:0] mk(input logic v, input logic ir, input logic dr,
                                     input logic wr, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] m,
                                     input logic [2:0] s);
    return {v, ir, dr, wr, a, d, m, s};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    io_iBus_cmd_valid        = 1'b0;
    io_dBus_cmd_valid        = 1'b0;
    io_dBus_cmd_payload_wr   = 1'b0;
    io_dBus_cmd_payload_size = 3'd2;
    io_mem_cmd_ready         = 1'b0;
    io_mem_rsp_valid         = 1'b0;
    io_mem_rsp_payload_data  = 32'h0;
    io_mem_rsp_payload_error = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Fire an iBus refill from IDLE; returns with the arbiter in RSP.
  task automatic fireRefill(input string name);
    io_iBus_cmd_valid = 1'b1;
    io_mem_cmd_ready  = 1'b1;
    #1;
    check({name, "_cmd"}, cmdOut, mk(1, 1, 0, 0, 32'h1020, 32'h0, 4'hF, 3'd5));
    tick();
    io_iBus_cmd_valid = 1'b0;
    io_mem_cmd_ready  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nBeats;
    logic [2:0]  sizes[3];
    logic [5:0]  expBeats[3];

    io_iBus_cmd_payload_address = 32'h0000_1020;
    io_iBus_cmd_payload_size    = 3'd5;
    io_dBus_cmd_payload_address = 32'h0000_0100;
    io_dBus_cmd_payload_data    = 32'hDEAD_BEEF;
    io_dBus_cmd_payload_mask    = 4'h3;
    clearInputs();
    reset = 1'b1;

    // Idle arbitration table, each vector starting from reset (lastGrant = iBus).
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, mk(1, 1, 0, 0, 32'h1020, 32'h0, 4'hF, 3'd5)};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 32'h1020, 32'h0, 4'hF, 3'd5)};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, mk(1, 0, 1, 1, 32'h100, 32'hDEADBEEF, 4'h3, 3'd2)};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, mk(1, 0, 1, 0, 32'h100, 32'hDEADBEEF, 4'h3, 3'd2)};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, mk(1, 0, 1, 1, 32'h100, 32'hDEADBEEF, 4'h3, 3'd2)};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 32'h100, 32'hDEADBEEF, 4'h3, 3'd2)};

    // Reset cycle: requests and a beat are present but nothing is passed on.
    io_iBus_cmd_valid = 1'b1;
    io_dBus_cmd_valid = 1'b1;
    io_mem_cmd_ready  = 1'b1;
    io_mem_rsp_valid  = 1'b1;
    #1;
    check("reset_gating", {io_mem_cmd_valid, io_iBus_cmd_ready, io_dBus_cmd_ready,
                           io_iBus_rsp_valid, io_dBus_rsp_valid}, 5'b0);
    tick();
    clearInputs();
    reset = 1'b0;
    check("reset_regs", {io_busy, io_protocolError}, 2'b00);

    for (int i = 0; i < 6; i++) begin
      doReset();
      io_iBus_cmd_valid      = vecs[i].iValid;
      io_dBus_cmd_valid      = vecs[i].dValid;
      io_dBus_cmd_payload_wr = vecs[i].dWr;
      io_mem_cmd_ready       = vecs[i].memReady;
      #1;
      check($sformatf("vec%0d", i), cmdOut, vecs[i].expCmd);
      tick();
    end

    // iBus refill alone: 8 beats, busy for exactly those 8 cycles.
    doReset();
    fireRefill("refill");
    for (int k = 0; k < 8; k++) begin
      io_mem_rsp_valid        = 1'b1;
      io_mem_rsp_payload_data = 32'hA0 + k;
      #1;
      check($sformatf("refill_beat%0d", k),
            {io_busy, io_mem_cmd_valid, io_iBus_rsp_valid, io_dBus_rsp_valid,
             io_iBus_rsp_payload_data},
            {1'b1, 1'b0, 1'b1, 1'b0, 32'hA0 + k});
      tick();
    end
    io_mem_rsp_valid = 1'b0;
    check("refill_done_busy", io_busy, 1'b0);
    io_dBus_cmd_valid      = 1'b1;
    io_dBus_cmd_payload_wr = 1'b1;
    io_mem_cmd_ready       = 1'b1;
    #1;
    check("refill_next_cmd", {io_dBus_cmd_ready, io_iBus_cmd_ready}, 2'b10);
    tick();

    // Simultaneous requests after reset, then round-robin on later ties.
    doReset();
    io_iBus_cmd_valid      = 1'b1;
    io_dBus_cmd_valid      = 1'b1;
    io_dBus_cmd_payload_wr = 1'b1;
    io_mem_cmd_ready       = 1'b1;
    #1;
    check("tie_first_dbus", cmdOut, mk(1, 0, 1, 1, 32'h100, 32'hDEADBEEF, 4'h3, 3'd2));
    tick();
    io_dBus_cmd_valid = 1'b0;
    #1;
    check("tie_then_ibus", cmdOut, mk(1, 1, 0, 0, 32'h1020, 32'h0, 4'hF, 3'd5));
    tick();
    io_iBus_cmd_valid = 1'b0;
    io_mem_cmd_ready  = 1'b0;
    io_mem_rsp_valid  = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    io_mem_rsp_valid = 1'b0;
    check("tie_burst_done", {io_busy, io_protocolError}, 2'b00);
    io_iBus_cmd_valid = 1'b1;
    io_dBus_cmd_valid = 1'b1;
    io_mem_cmd_ready  = 1'b1;
    #1;
    check("tie_after_ibus", {io_dBus_cmd_ready, io_iBus_cmd_ready}, 2'b10);
    tick();
    #1;
    check("tie_after_dbus", {io_dBus_cmd_ready, io_iBus_cmd_ready}, 2'b01);
    tick();

    // Grant hold: dBus read stalled 3 cycles while iBus waits.
    doReset();
    io_iBus_cmd_valid      = 1'b1;
    io_dBus_cmd_valid      = 1'b1;
    io_dBus_cmd_payload_wr = 1'b0;
    io_mem_cmd_ready       = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold_stall%0d", c), cmdOut,
            mk(1, 0, 0, 0, 32'h100, 32'hDEADBEEF, 4'h3, 3'd2));
      tick();
      check($sformatf("hold_busy%0d", c), io_busy, 1'b1);
    end
    io_mem_cmd_ready = 1'b1;
    #1;
    check("hold_fire", cmdOut, mk(1, 0, 1, 0, 32'h100, 32'hDEADBEEF, 4'h3, 3'd2));
    tick();
    io_dBus_cmd_valid       = 1'b0;
    io_mem_rsp_valid        = 1'b1;
    io_mem_rsp_payload_data = 32'h55;
    #1;
    check("hold_rsp", {io_mem_cmd_valid, io_iBus_cmd_ready, io_iBus_rsp_valid,
                       io_dBus_rsp_valid, io_dBus_rsp_payload_data, io_iBus_rsp_payload_data},
          {1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 32'h55});
    tick();
    io_mem_rsp_valid = 1'b0;
    #1;
    check("hold_release", {io_busy, io_iBus_cmd_ready}, 2'b01);
    tick();

    // Error on beat 3 of a refill: forwarded, counting continues.
    doReset();
    fireRefill("err");
    for (int k = 0; k < 8; k++) begin
      io_mem_rsp_valid         = 1'b1;
      io_mem_rsp_payload_error = (k == 3);
      #1;
      check($sformatf("err_beat%0d", k),
            {io_iBus_rsp_valid, io_dBus_rsp_valid, io_iBus_rsp_payload_error,
             io_dBus_rsp_payload_error},
            {1'b1, 1'b0, (k == 3) ? 1'b1 : 1'b0, (k == 3) ? 1'b1 : 1'b0});
      tick();
    end
    clearInputs();
    check("err_done", {io_busy, io_protocolError}, 2'b00);

    // Stray response in IDLE: dropped and sticky error set.
    doReset();
    io_mem_rsp_valid = 1'b1;
    #1;
    check("stray_dropped", {io_iBus_rsp_valid, io_dBus_rsp_valid}, 2'b00);
    tick();
    io_mem_rsp_valid = 1'b0;
    check("stray_flag", {io_protocolError, io_busy}, 2'b10);
    tick();
    tick();
    check("stray_sticky", io_protocolError, 1'b1);
    doReset();
    check("stray_cleared", io_protocolError, 1'b0);

    // Beat counts at the size boundaries.
    sizes    = '{3'd0, 3'd3, 3'd7};
    expBeats = '{6'd1, 6'd2, 6'd32};
    for (int s = 0; s < 3; s++) begin
      doReset();
      io_dBus_cmd_valid        = 1'b1;
      io_dBus_cmd_payload_size = sizes[s];
      io_mem_cmd_ready         = 1'b1;
      tick();
      io_dBus_cmd_valid = 1'b0;
      io_mem_cmd_ready  = 1'b0;
      io_mem_rsp_valid  = 1'b1;
      nBeats = 0;
      for (int b = 0; b < 40; b++) begin
        tick();
        nBeats++;
        if (!io_busy) break;
      end
      io_mem_rsp_valid = 1'b0;
      check($sformatf("beats_size%0d", sizes[s]), nBeats, expBeats[s]);
    end

    // Reset after 4 of 8 beats: remaining beats are strays.
    doReset();
    fireRefill("midrst");
    io_mem_rsp_valid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    reset                  = 1'b1;
    io_dBus_cmd_valid      = 1'b1;
    io_dBus_cmd_payload_wr = 1'b1;
    io_mem_cmd_ready       = 1'b1;
    #1;
    check("midrst_gating", {io_iBus_rsp_valid, io_mem_cmd_valid, io_dBus_cmd_ready}, 3'b000);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_state", {io_busy, io_protocolError}, 2'b00);
    check("midrst_new_cmd", {io_iBus_rsp_valid, io_dBus_rsp_valid, io_mem_cmd_valid,
                             io_dBus_cmd_ready, io_mem_cmd_payload_wr}, 5'b00111);
    tick();
    io_dBus_cmd_valid = 1'b0;
    check("midrst_flag", {io_protocolError, io_busy}, 2'b10);
    tick();
    tick();
    io_mem_rsp_valid = 1'b0;
    check("midrst_sticky", io_protocolError, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
